// File: rtl/code2421_display.sv
// 2421 (Aiken) digit decoder with tens counter and a two-digit multiplexed 7-segment driver.
// Define CODE2421_ERR_HOLD_EN to make err sticky until reset; otherwise err clears on the next valid sample.
module code2421_display #(
    parameter int unsigned REFRESH_DIV = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] code_in,
    input  logic       sample,
    output logic [3:0] bcd_units,
    output logic [3:0] bcd_tens,
    output logic       carry_out,
    output logic       err,
    output logic [6:0] seg,
    output logic [1:0] an
);

    localparam int unsigned LastCount = REFRESH_DIV - 1;
    localparam logic [15:0] CntLast   = LastCount[15:0];
    localparam logic [6:0]  SegBlank  = 7'b1111111;

    logic [3:0]  units_q, units_d;
    logic [3:0]  tens_q, tens_d;
    logic [3:0]  prev_q, prev_d;
    logic        carry_q, carry_d;
    logic        err_q, err_d;
    logic [15:0] cnt_q, cnt_d;
    logic        sel_q, sel_d;
    logic [6:0]  seg_q, seg_d;
    logic [1:0]  an_q, an_d;

    logic        code_valid;
    logic [3:0]  code_digit;
    logic        blank_units;

    function automatic logic [6:0] seg_pattern(input logic [3:0] d);
        logic [6:0] p;
        case (d)
            4'd0:    p = 7'b1000000;
            4'd1:    p = 7'b1111001;
            4'd2:    p = 7'b0100100;
            4'd3:    p = 7'b0110000;
            4'd4:    p = 7'b0011001;
            4'd5:    p = 7'b0010010;
            4'd6:    p = 7'b0000010;
            4'd7:    p = 7'b1111000;
            4'd8:    p = 7'b0000000;
            4'd9:    p = 7'b0010000;
            default: p = SegBlank;
        endcase
        return p;
    endfunction

    always_comb begin
        code_valid = 1'b1;
        code_digit = 4'd0;
        case (code_in)
            4'b0000: code_digit = 4'd0;
            4'b0001: code_digit = 4'd1;
            4'b0010: code_digit = 4'd2;
            4'b0011: code_digit = 4'd3;
            4'b0100: code_digit = 4'd4;
            4'b1011: code_digit = 4'd5;
            4'b1100: code_digit = 4'd6;
            4'b1101: code_digit = 4'd7;
            4'b1110: code_digit = 4'd8;
            4'b1111: code_digit = 4'd9;
            default: code_valid = 1'b0;
        endcase
    end

    // Wrap is keyed on the last valid digit, so idle cycles between 9 and 0 do not matter.
    always_comb begin
        units_d = units_q;
        prev_d  = prev_q;
        tens_d  = tens_q;
        carry_d = 1'b0;
        err_d   = err_q;
        if (sample) begin
            if (code_valid) begin
                units_d = code_digit;
                prev_d  = code_digit;
                if (code_digit == 4'd0 && prev_q == 4'd9) begin
                    carry_d = 1'b1;
                    tens_d  = (tens_q == 4'd9) ? 4'd0 : tens_q + 4'd1;
                end
`ifndef CODE2421_ERR_HOLD_EN
                err_d = 1'b0;
`endif
            end else begin
                err_d = 1'b1;
            end
        end
    end

`ifdef CODE2421_ERR_HOLD_EN
    assign blank_units = 1'b0;
`else
    assign blank_units = err_q;
`endif

    always_comb begin
        cnt_d = cnt_q + 16'd1;
        sel_d = sel_q;
        if (cnt_q >= CntLast) begin
            cnt_d = 16'd0;
            sel_d = ~sel_q;
        end
    end

    always_comb begin
        if (sel_q) begin
            an_d  = 2'b01;
            seg_d = seg_pattern(tens_q);
        end else begin
            an_d  = 2'b10;
            seg_d = blank_units ? SegBlank : seg_pattern(units_q);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            units_q <= 4'd0;
            tens_q  <= 4'd0;
            prev_q  <= 4'd0;
            carry_q <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= 16'd0;
            sel_q   <= 1'b0;
            an_q    <= 2'b10;
            seg_q   <= 7'b1000000;
        end else begin
            units_q <= units_d;
            tens_q  <= tens_d;
            prev_q  <= prev_d;
            carry_q <= carry_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
        end
    end

    assign bcd_units = units_q;
    assign bcd_tens  = tens_q;
    assign carry_out = carry_q;
    assign err       = err_q;
    assign seg       = seg_q;
    assign an        = an_q;

endmodule

// File: tb/tb_code2421_display.sv
// Directed-vector bench for code2421_display, built with REFRESH_DIV=4.
module tb_code2421_display;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] code_in = 4'd0;
    logic       sample = 1'b0;
    logic [3:0] bcd_units;
    logic [3:0] bcd_tens;
    logic       carry_out;
    logic       err;
    logic [6:0] seg;
    logic [1:0] an;

    int vectors = 0;
    int miscompares = 0;
    int edges = 0;

    logic [3:0] codes [10];

    code2421_display #(.REFRESH_DIV(4)) dut (
        .clock     (clock),
        .reset     (reset),
        .code_in   (code_in),
        .sample    (sample),
        .bcd_units (bcd_units),
        .bcd_tens  (bcd_tens),
        .carry_out (carry_out),
        .err       (err),
        .seg       (seg),
        .an        (an)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
        edges++;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        sample = 1'b0;
        code_in = 4'd0;
        tick();
        reset = 1'b0;
        edges = 0;
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if (bcd_units !== 4'd0) begin
            miscompares++; $display("FAIL reset_units got %h want 0", bcd_units);
        end
        vectors++;
        if (bcd_tens !== 4'd0) begin
            miscompares++; $display("FAIL reset_tens got %h want 0", bcd_tens);
        end
        vectors++;
        if (carry_out !== 1'b0 || err !== 1'b0) begin
            miscompares++; $display("FAIL reset_flags got carry=%b err=%b want 0 0", carry_out, err);
        end
        vectors++;
        if (an !== 2'b10 || seg !== 7'b1000000) begin
            miscompares++; $display("FAIL reset_display got an=%b seg=%b want 10 1000000", an, seg);
        end
    endtask

    task automatic test_decode_sequence();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            sample = 1'b1;
            code_in = codes[i];
            tick();
            vectors++;
            if (bcd_units !== 4'(i) || bcd_tens !== 4'd0 || carry_out !== 1'b0) begin
                miscompares++;
                $display("FAIL decode_%0d got units=%h tens=%h carry=%b want %0d 0 0",
                         i, bcd_units, bcd_tens, carry_out, i);
            end
        end
    endtask

    // Continues from digit 9 left by test_decode_sequence.
    task automatic test_wrap_chain();
        int carries;
        sample = 1'b1;
        code_in = 4'b0000;
        tick();
        vectors++;
        if (bcd_units !== 4'd0 || bcd_tens !== 4'd1 || carry_out !== 1'b1) begin
            miscompares++;
            $display("FAIL first_wrap got units=%h tens=%h carry=%b want 0 1 1",
                     bcd_units, bcd_tens, carry_out);
        end
        sample = 1'b0;
        tick();
        vectors++;
        if (carry_out !== 1'b0) begin
            miscompares++; $display("FAIL carry_width got carry=%b want 0", carry_out);
        end
        carries = 0;
        for (int w = 0; w < 10; w++) begin
            for (int d = 1; d <= 10; d++) begin
                sample = 1'b1;
                code_in = codes[d % 10];
                tick();
                if (carry_out === 1'b1) carries++;
            end
            vectors++;
            if (bcd_tens !== 4'((2 + w) % 10) || bcd_units !== 4'd0) begin
                miscompares++;
                $display("FAIL wrap_loop_%0d got tens=%h units=%h want %0d 0",
                         w, bcd_tens, bcd_units, (2 + w) % 10);
            end
        end
        vectors++;
        if (carries != 10) begin
            miscompares++; $display("FAIL carry_count got %0d want 10", carries);
        end
        vectors++;
        if (bcd_tens !== 4'd1) begin
            miscompares++; $display("FAIL tens_rollover got %h want 1", bcd_tens);
        end
    endtask

    task automatic test_idle_wrap();
        do_reset();
        sample = 1'b1;
        code_in = 4'b1111;
        tick();
        vectors++;
        if (carry_out !== 1'b0 || bcd_units !== 4'd9) begin
            miscompares++; $display("FAIL idle_nine got carry=%b units=%h want 0 9", carry_out, bcd_units);
        end
        sample = 1'b0;
        for (int i = 0; i < 5; i++) begin
            code_in = (i == 2) ? 4'b0110 : 4'b0000;
            tick();
            vectors++;
            if (carry_out !== 1'b0 || bcd_units !== 4'd9 || err !== 1'b0) begin
                miscompares++;
                $display("FAIL idle_hold_%0d got carry=%b units=%h err=%b want 0 9 0",
                         i, carry_out, bcd_units, err);
            end
        end
        sample = 1'b1;
        code_in = 4'b0000;
        tick();
        vectors++;
        if (carry_out !== 1'b1 || bcd_units !== 4'd0 || bcd_tens !== 4'd1) begin
            miscompares++;
            $display("FAIL idle_wrap got carry=%b units=%h tens=%h want 1 0 1",
                     carry_out, bcd_units, bcd_tens);
        end
        tick();
        vectors++;
        if (carry_out !== 1'b0 || bcd_tens !== 4'd1) begin
            miscompares++;
            $display("FAIL repeat_zero got carry=%b tens=%h want 0 1", carry_out, bcd_tens);
        end
        sample = 1'b0;
    endtask

    task automatic test_error();
        logic       err_after;
        logic [6:0] seg_after;
`ifdef CODE2421_ERR_HOLD_EN
        err_after = 1'b1;
        seg_after = 7'b1111000;
`else
        err_after = 1'b0;
        seg_after = 7'b1111111;
`endif
        do_reset();
        sample = 1'b1;
        code_in = 4'b1101;
        tick();
        code_in = 4'b0110;
        tick();
        vectors++;
        if (err !== 1'b1 || bcd_units !== 4'd7) begin
            miscompares++; $display("FAIL err_set got err=%b units=%h want 1 7", err, bcd_units);
        end
        code_in = 4'b0001;
        tick();
        vectors++;
        if (err !== err_after || bcd_units !== 4'd1) begin
            miscompares++;
            $display("FAIL err_after_valid got err=%b units=%h want %b 1", err, bcd_units, err_after);
        end
        vectors++;
        if (seg !== seg_after || an !== 2'b10) begin
            miscompares++;
            $display("FAIL err_display got seg=%b an=%b want %b 10", seg, an, seg_after);
        end
        sample = 1'b0;
        tick();
        vectors++;
        if (seg !== 7'b1111001) begin
            miscompares++; $display("FAIL err_unblank got seg=%b want 1111001", seg);
        end
    endtask

    task automatic test_refresh();
        int         s;
        logic [1:0] an_exp;
        logic [6:0] seg_exp;
        do_reset();
        sample = 1'b1;
        for (int w = 0; w < 5; w++) begin
            code_in = 4'b1111;
            tick();
            code_in = 4'b0000;
            tick();
        end
        code_in = 4'b0011;
        tick();
        sample = 1'b0;
        vectors++;
        if (bcd_units !== 4'd3 || bcd_tens !== 4'd5) begin
            miscompares++;
            $display("FAIL refresh_setup got units=%h tens=%h want 3 5", bcd_units, bcd_tens);
        end
        for (int k = 0; k < 16; k++) begin
            tick();
            // Display registers lag the select by one edge; select flips every 4 edges.
            s = ((edges - 1) / 4) % 2;
            an_exp  = (s == 1) ? 2'b01 : 2'b10;
            seg_exp = (s == 1) ? 7'b0010010 : 7'b0110000;
            vectors++;
            if (an !== an_exp || seg !== seg_exp) begin
                miscompares++;
                $display("FAIL refresh_edge_%0d got an=%b seg=%b want %b %b",
                         edges, an, seg, an_exp, seg_exp);
            end
        end
    endtask

    task automatic test_reset_priority();
        do_reset();
        sample = 1'b1;
        code_in = 4'b1111;
        tick();
        reset = 1'b1;
        code_in = 4'b0000;
        tick();
        reset = 1'b0;
        vectors++;
        if (bcd_units !== 4'd0 || bcd_tens !== 4'd0 || carry_out !== 1'b0 || err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_prio got units=%h tens=%h carry=%b err=%b want 0 0 0 0",
                     bcd_units, bcd_tens, carry_out, err);
        end
        vectors++;
        if (an !== 2'b10 || seg !== 7'b1000000) begin
            miscompares++; $display("FAIL reset_prio_disp got an=%b seg=%b want 10 1000000", an, seg);
        end
        tick();
        vectors++;
        if (carry_out !== 1'b0 || bcd_tens !== 4'd0) begin
            miscompares++;
            $display("FAIL post_reset_zero got carry=%b tens=%h want 0 0", carry_out, bcd_tens);
        end
        sample = 1'b0;
    endtask

    initial begin
        codes[0] = 4'b0000; codes[1] = 4'b0001; codes[2] = 4'b0010; codes[3] = 4'b0011;
        codes[4] = 4'b0100; codes[5] = 4'b1011; codes[6] = 4'b1100; codes[7] = 4'b1101;
        codes[8] = 4'b1110; codes[9] = 4'b1111;
        test_reset();
        test_decode_sequence();
        test_wrap_chain();
        test_idle_wrap();
        test_error();
        test_refresh();
        test_reset_priority();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
